// File: rtl/sign_arbiter.sv
// Two-requester round-robin arbiter that captures one sample and reports its sign/zero flags.
// Latency: result valid 1 clock after accept; at most one sample per 2 clocks.
// Backpressure: the result is held until out_ready; no requester is granted while a result is pending.
module sign_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid0,
  input  logic [WIDTH-1:0] in_data0,
  output logic             in_ready0,
  input  logic             in_valid1,
  input  logic [WIDTH-1:0] in_data1,
  output logic             in_ready1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sign,
  output logic             out_zero,
  output logic             out_src,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] neg_cnt0,
  output logic [CNT_W-1:0] neg_cnt1
);

  typedef enum logic {IDLE = 1'b0, REPORT = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic             last_src;
  logic             gnt_idx;
  logic             accept;
  logic [WIDTH-1:0] sel_data;
  logic             sel_neg;

  // Grant selection: a lone requester wins; on a tie the one that did not win last time wins.
  // Readies depend only on state, valids and last_src, never on out_ready.
  always_comb begin
    gnt_idx   = (in_valid0 && in_valid1) ? ~last_src : in_valid1;
    in_ready0 = (state == IDLE) && in_valid0 && !gnt_idx;
    in_ready1 = (state == IDLE) && in_valid1 && gnt_idx;
    accept    = in_ready0 || in_ready1;
    sel_data  = gnt_idx ? in_data1 : in_data0;
    sel_neg   = sel_data[WIDTH-1];
  end

  // Control FSM: capture on accept, hold the result until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sign  <= 1'b0;
      out_zero  <= 1'b0;
      out_src   <= 1'b0;
      last_src  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_data  <= sel_data;
            out_sign  <= sel_neg;
            out_zero  <= (sel_data == '0);
            out_src   <= gnt_idx;
            last_src  <= gnt_idx;
            out_valid <= 1'b1;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Saturating per-requester negative-sample counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_cnt0 <= '0;
      neg_cnt1 <= '0;
    end else if (clr_cnt) begin
      neg_cnt0 <= '0;
      neg_cnt1 <= '0;
    end else if (accept && sel_neg) begin
      if (!gnt_idx && neg_cnt0 != CNT_MAX) neg_cnt0 <= neg_cnt0 + CNT_ONE;
      if (gnt_idx && neg_cnt1 != CNT_MAX)  neg_cnt1 <= neg_cnt1 + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_sign_arbiter.sv
// Self-checking bench for sign_arbiter: vector table plus hand-written multi-cycle sequences.
// Expected results are queued when stimulus is driven and popped when the DUT presents a result.
module tb_sign_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid0, in_valid1, in_ready0, in_ready1;
  logic [7:0] in_data0, in_data1;
  logic       out_valid, out_ready, out_sign, out_zero, out_src, clr_cnt;
  logic [7:0] out_data, neg_cnt0, neg_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [7:0] data;
    logic       sign;
    logic       zero;
    logic       src;
  } res_t;

  typedef struct {
    logic       v0;
    logic [7:0] d0;
    logic       v1;
    logic [7:0] d1;
    logic       r0;
    logic       r1;
    logic [7:0] ed;
    logic       es;
    logic       ez;
    logic       esrc;
  } vec_t;

  res_t sb[$];
  vec_t vecs[7];
  logic mdl_last;

  sign_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid0(in_valid0), .in_data0(in_data0), .in_ready0(in_ready0),
    .in_valid1(in_valid1), .in_data1(in_data1), .in_ready1(in_ready1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sign(out_sign), .out_zero(out_zero), .out_src(out_src),
    .clr_cnt(clr_cnt), .neg_cnt0(neg_cnt0), .neg_cnt1(neg_cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic s, input logic z, input logic src);
    res_t e;
    e.data = d; e.sign = s; e.zero = z; e.src = src;
    sb.push_back(e);
  endtask

  task automatic check_out(input string name);
    res_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: result %h seen with nothing expected", name, out_data);
    end else begin
      e = sb.pop_front();
      chk(name, {out_valid, out_data, out_sign, out_zero, out_src}, {1'b1, e});
    end
  endtask

  task automatic do_reset();
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_data0 = 8'h00; in_data1 = 8'h00;
    clr_cnt = 1'b0; out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid0 = 1'b0; in_valid1 = 1'b0; in_data0 = 8'h00; in_data1 = 8'h00;
    clr_cnt = 1'b0; out_ready = 1'b1;

    //                 v0    d0     v1    d1     r0    r1    ed     es    ez    esrc
    vecs[0] = '{1'b1, 8'h85, 1'b0, 8'h00, 1'b1, 1'b0, 8'h85, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h02, 1'b1, 8'hFE, 1'b0, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 8'h00, 1'b1, 8'h81, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};

    // Reset values while reset is held
    @(negedge clk);
    #1;
    chk("reset_out", {out_valid, out_data, out_sign, out_zero, out_src}, 12'h000);
    chk("reset_cnt", {neg_cnt0, neg_cnt1}, 16'h0000);
    chk("reset_rdy", {in_ready0, in_ready1}, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    // Vector table: single requesters, boundary samples and ties
    foreach (vecs[i]) begin
      @(negedge clk);
      in_valid0 = vecs[i].v0; in_data0 = vecs[i].d0;
      in_valid1 = vecs[i].v1; in_data1 = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d_rdy", i), {in_ready0, in_ready1}, {vecs[i].r0, vecs[i].r1});
      push_exp(vecs[i].ed, vecs[i].es, vecs[i].ez, vecs[i].esrc);
      @(negedge clk);
      in_valid0 = 1'b0; in_valid1 = 1'b0;
      check_out($sformatf("vec%0d_out", i));
      @(negedge clk);
      chk($sformatf("vec%0d_idle", i), out_valid, 1'b0);
    end
    chk("vec_cnt0", neg_cnt0, 8'd2);
    chk("vec_cnt1", neg_cnt1, 8'd2);

    // Tie with held data: round-robin over four results
    do_reset();
    mdl_last = 1'b1;
    in_valid0 = 1'b1; in_data0 = 8'h10;
    in_valid1 = 1'b1; in_data1 = 8'hF0;
    for (int i = 0; i < 4; i++) begin
      logic src;
      src = ~mdl_last;
      mdl_last = src;
      push_exp(src ? 8'hF0 : 8'h10, src, 1'b0, src);
      for (int w = 0; w < 6 && !out_valid; w++) @(negedge clk);
      check_out($sformatf("rr%0d", i));
      if (i == 3) begin
        in_valid0 = 1'b0; in_valid1 = 1'b0;
      end
      @(negedge clk);
    end
    chk("rr_cnt0", neg_cnt0, 8'd0);
    chk("rr_cnt1", neg_cnt1, 8'd2);

    // Backpressure: result held for five cycles, waiting requester not granted
    out_ready = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'hC3;
    in_valid1 = 1'b1; in_data1 = 8'h11;
    push_exp(8'hC3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid0 = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_hold%0d", c),
          {out_valid, out_data, out_sign, out_zero, out_src, in_ready0, in_ready1},
          {1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
      @(negedge clk);
    end
    check_out("bp_out");
    out_ready = 1'b1;
    push_exp(8'h11, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp_handoff", {out_valid, in_ready0, in_ready1}, 3'b001);
    @(negedge clk);
    in_valid1 = 1'b0;
    check_out("bp_next");
    @(negedge clk);
    chk("bp_idle", out_valid, 1'b0);

    // Saturation: 260 negative samples from requester 0
    do_reset();
    in_valid0 = 1'b1; in_data0 = 8'h90;
    repeat (519) @(negedge clk);
    in_valid0 = 1'b0;
    chk("sat_cnt0", neg_cnt0, 8'd255);
    chk("sat_cnt1", neg_cnt1, 8'd0);
    @(negedge clk);

    // Clear coincident with a negative accept
    in_valid0 = 1'b1; in_data0 = 8'h80; clr_cnt = 1'b1;
    push_exp(8'h80, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid0 = 1'b0; clr_cnt = 1'b0;
    chk("clr_cnt0", neg_cnt0, 8'd0);
    check_out("clr_out");
    @(negedge clk);

    // Reset while a result is pending
    out_ready = 1'b0;
    in_valid0 = 1'b1; in_data0 = 8'hF1;
    @(negedge clk);
    in_valid0 = 1'b0;
    chk("mr_pending", {out_valid, neg_cnt0}, {1'b1, 8'd1});
    #2 rst_n = 1'b0;
    #1;
    chk("mr_async", {out_valid, out_data, neg_cnt0, neg_cnt1}, {1'b0, 8'h00, 8'd0, 8'd0});
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    in_valid0 = 1'b1; in_data0 = 8'h05;
    in_valid1 = 1'b1; in_data1 = 8'hF5;
    #1;
    chk("mr_tie_rdy", {in_ready0, in_ready1}, 2'b10);
    push_exp(8'h05, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    in_valid0 = 1'b0; in_valid1 = 1'b0;
    check_out("mr_tie_out");
    @(negedge clk);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sign_arbiter.md
SIGN_ARBITER -- requirements
Module: sign_arbiter

Interface
REQ-001 Parameter: WIDTH, 8, sample width in bits; bit WIDTH-1 is the two's-complement sign bit.
REQ-002 Parameter: CNT_W, 8, width of each per-requester negative-sample counter.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid0  input  1  requester 0 offers a sample.
REQ-006 in_data0  input  WIDTH  requester 0 sample.
REQ-007 in_ready0  output  1  requester 0 sample accepted this cycle when high together with in_valid0.
REQ-008 in_valid1  input  1  requester 1 offers a sample.
REQ-009 in_data1  input  WIDTH  requester 1 sample.
REQ-010 in_ready1  output  1  requester 1 accept strobe.
REQ-011 out_valid  output  1  result held for the consumer.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 out_data  output  WIDTH  captured sample.
REQ-014 out_sign  output  1  1 = captured sample negative.
REQ-015 out_zero  output  1  1 = captured sample equals 0.
REQ-016 out_src  output  1  index of the requester that supplied the sample.
REQ-017 clr_cnt  input  1  synchronous clear of both counters.
REQ-018 neg_cnt0  output  CNT_W  negative samples accepted from requester 0.
REQ-019 neg_cnt1  output  CNT_W  negative samples accepted from requester 1.

Function
REQ-020 The FSM SHALL have exactly two states: IDLE and REPORT.
REQ-021 In IDLE, in_ready SHALL be driven combinationally high for the granted requester only, and only if its in_valid is high; in REPORT, both in_ready SHALL be 0.
REQ-022 Grant SHALL be round-robin: if only one in_valid is high, grant it; if both are high, grant the requester other than last_src.
REQ-023 last_src SHALL update to the granted index on every accept and SHALL reset to 1, so requester 0 wins the first tie.
REQ-024 On accept (in IDLE with a granted in_valid): capture the sample into out_data; out_sign = sample[WIDTH-1]; out_zero = (sample == 0); out_src = granted index; transition to REPORT. out_valid SHALL go high on the next cycle, giving a latency of 1 clock.
REQ-025 In REPORT, out_valid SHALL be 1 and out_data, out_sign, out_zero, and out_src SHALL be held stable until out_valid && out_ready, after which the FSM SHALL return to IDLE on that edge.
REQ-026 A new accept SHALL NOT occur in the same cycle as a result handoff; maximum throughput is one sample per 2 cycles.
REQ-027 A requester holding in_valid without a grant SHALL keep its data stable; the block SHALL NOT drop or reorder a requester's samples.
REQ-028 On accept of a negative sample, the counter of the supplying requester SHALL increment by 1 and SHALL saturate at 2^CNT_W-1.
REQ-029 When clr_cnt = 1, both counters SHALL become 0 on the next edge; clr_cnt SHALL take priority over a simultaneous increment.
REQ-030 clr_cnt SHALL NOT affect the FSM, out_* outputs, or last_src.
REQ-031 out_valid SHALL be registered; in_ready SHALL have no combinational path from out_ready.

Reset
REQ-032 When rst_n = 0, the block SHALL asynchronously force: FSM = IDLE, out_valid = 0, out_data = 0, out_sign = 0, out_zero = 0, out_src = 0, last_src = 1, neg_cnt0 = 0, neg_cnt1 = 0.
REQ-033 A reset asserted while in REPORT SHALL discard the pending result with no handoff; counters SHALL NOT be restored.
REQ-034 After rst_n is deasserted, the first accept SHALL be possible on the first rising edge.

Verification
REQ-035 Single requester: in_valid0 = 1, in_data0 = 8'h85, out_ready = 1 -> one cycle later out_valid = 1, out_sign = 1, out_zero = 0, out_src = 0, out_data = 8'h85; neg_cnt0 = 1.
REQ-036 Tie plus round-robin: both valid with 8'h10 and 8'hF0 held for 4 results -> out_src sequence 0,1,0,1; neg_cnt1 = 2; neg_cnt0 = 0.
REQ-037 Backpressure: out_ready = 0 for 5 cycles while in REPORT -> outputs stable, both in_ready = 0; out_ready = 1 -> handoff, then IDLE.
REQ-038 Boundary values: samples 8'h00, 8'h7F, 8'h80, 8'hFF -> out_zero = 1,0,0,0 and out_sign = 0,0,1,1.
REQ-039 Saturation and clear: 260 negative samples from requester 0 with CNT_W = 8 -> neg_cnt0 = 255; clr_cnt coincident with a negative accept -> neg_cnt0 = 0.
REQ-040 Mid-operation reset: rst_n pulsed low in REPORT -> out_valid = 0 immediately, counters = 0, next tie grants requester 0.
